// File: rtl/core_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_ctrl_pkg
// Shared definitions for the core run/stop controller.
//   run_state_t : lifecycle states of the controller FSM
//   HALT_INSTR  : the all-zero machine word; a run of these ends a program
// -----------------------------------------------------------------------------
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam logic [8:0] HALT_INSTR = 9'h000;

endpackage

// File: rtl/core_run_controller_if.sv
// -----------------------------------------------------------------------------
// core_run_controller_if
// Bundles the controller's control/status signals.
//   master : start/abort requests and the core's pc/mach_code observation
//   slave  : the controller; drives core_rst, core_en, busy, done, timeout,
//            cycle_count
// -----------------------------------------------------------------------------
interface core_run_controller_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) ();

    logic               start;
    logic               abort;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] mach_code;

    logic               core_rst;
    logic               core_en;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [CNT_W-1:0]   cycle_count;

    modport master (
        output start, abort, pc, mach_code,
        input  core_rst, core_en, busy, done, timeout, cycle_count
    );

    modport slave (
        input  start, abort, pc, mach_code,
        output core_rst, core_en, busy, done, timeout, cycle_count
    );

endinterface

// File: rtl/halt_detector.sv
// -----------------------------------------------------------------------------
// halt_detector
// Watches the fetched instruction stream and PC during RUN and flags the end
// of a program.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zeroes the zero-run counter (a new run is being started)
//   run        : high while the core is executing; gates counting and halt_hit
//   pc         : current program counter
//   mach_code  : instruction currently fetched
//   halt_hit   : combinational; the current RUN cycle ends the program
// -----------------------------------------------------------------------------
module halt_detector
    import core_ctrl_pkg::*;
#(
    parameter int              PC_W       = 8,
    parameter int              INSTR_W    = 9,
    parameter int              HALT_ZEROS = 2,
    parameter logic [PC_W-1:0] HALT_PC    = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               run,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] mach_code,
    output logic               halt_hit
);

    // Counter must be able to hold HALT_ZEROS-1; one extra bit of headroom
    // lets it saturate harmlessly if run stays high past a halt.
    localparam int           ZW    = $clog2(HALT_ZEROS + 1);
    localparam logic [ZW-1:0] ZLAST = ZW'(HALT_ZEROS - 1);

    logic [ZW-1:0] zero_cnt_reg;
    logic          is_zero;

    assign is_zero = (mach_code == INSTR_W'(HALT_INSTR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_cnt_reg <= '0;
        end else if (clear) begin
            zero_cnt_reg <= '0;
        end else if (run) begin
            if (!is_zero)
                zero_cnt_reg <= '0;
            else if (zero_cnt_reg != '1)
                zero_cnt_reg <= zero_cnt_reg + 1'b1;
        end
    end

    // The counter holds the number of zero words seen *before* this cycle, so
    // the HALT_ZEROS-th consecutive zero is the one seen when it equals ZLAST.
    assign halt_hit = run && ((pc == HALT_PC) || (is_zero && (zero_cnt_reg == ZLAST)));

endmodule

// File: rtl/core_run_controller.sv
// -----------------------------------------------------------------------------
// core_run_controller
// Owns the run/stop lifecycle of the small 9-bit core: turns a start request
// into a core reset window (CLEAR), a gated run phase (RUN) and a sticky done
// indication (DONE). Programs end on a run of zero instructions, a terminal PC
// or an optional cycle budget.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of core_run_controller_if
//           start/abort in, pc/mach_code observed from the core,
//           core_rst/core_en/busy/done/timeout/cycle_count out (all registered)
// -----------------------------------------------------------------------------
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int               PC_W         = 8,
    parameter int               INSTR_W      = 9,
    parameter int               CNT_W        = 16,
    parameter int               CLEAR_CYCLES = 2,
    parameter int               HALT_ZEROS   = 2,
    parameter logic [PC_W-1:0]  HALT_PC      = 8'hFF,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    core_run_controller_if.slave bus
);

    localparam int               CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = MAX_CYCLES - 1'b1;

    run_state_t       state_reg;
    logic [CLR_W-1:0] clr_cnt_reg;
    logic [CNT_W-1:0] cycle_count_reg;
    logic             core_rst_reg;
    logic             core_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             timeout_reg;

    logic             in_run;
    logic             start_accept;
    logic             halt_hit;
    logic             timeout_hit;
    logic [CNT_W-1:0] cycle_count_next;

    assign in_run = (state_reg == RUN);

    // A start is taken from IDLE, or from DONE unless abort overrides it.
    assign start_accept = bus.start &&
                          ((state_reg == IDLE) || ((state_reg == DONE) && !bus.abort));

    // Budget check looks at the count before this cycle's increment, so the
    // MAX_CYCLES-th RUN cycle is the last one.
    assign timeout_hit = (MAX_CYCLES != '0) && (cycle_count_reg == MAX_LAST);

    // Saturating increment: a very long run pins the count at all-ones.
    assign cycle_count_next = (cycle_count_reg == '1) ? cycle_count_reg
                                                      : cycle_count_reg + 1'b1;

    halt_detector #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .HALT_ZEROS (HALT_ZEROS),
        .HALT_PC    (HALT_PC)
    ) u_halt_detector (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_accept),
        .run       (in_run),
        .pc        (bus.pc),
        .mach_code (bus.mach_code),
        .halt_hit  (halt_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            clr_cnt_reg     <= '0;
            cycle_count_reg <= '0;
            core_rst_reg    <= 1'b1;
            core_en_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    core_rst_reg <= 1'b1;
                    core_en_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (bus.start) begin
                        state_reg       <= CLEAR;
                        clr_cnt_reg     <= '0;
                        cycle_count_reg <= '0;
                        done_reg        <= 1'b0;
                        timeout_reg     <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (bus.abort) begin
                        state_reg    <= IDLE;
                        core_rst_reg <= 1'b1;
                        core_en_reg  <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b0;
                        timeout_reg  <= 1'b0;
                    end else if (clr_cnt_reg == CLR_LAST) begin
                        // Release the core on the edge that ends the window so
                        // core_en is high in the very next cycle.
                        state_reg    <= RUN;
                        core_rst_reg <= 1'b0;
                        core_en_reg  <= 1'b1;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end

                RUN: begin
                    if (bus.abort) begin
                        // cycle_count is left as-is for inspection.
                        state_reg    <= IDLE;
                        core_rst_reg <= 1'b1;
                        core_en_reg  <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b0;
                        timeout_reg  <= 1'b0;
                    end else begin
                        cycle_count_reg <= cycle_count_next;
                        if (halt_hit || timeout_hit) begin
                            state_reg   <= DONE;
                            core_en_reg <= 1'b0;
                            busy_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            // A genuine halt in the budget's last cycle is a
                            // clean finish, not a timeout.
                            timeout_reg <= !halt_hit;
                        end
                    end
                end

                DONE: begin
                    if (bus.abort) begin
                        state_reg    <= IDLE;
                        core_rst_reg <= 1'b1;
                        core_en_reg  <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b0;
                        timeout_reg  <= 1'b0;
                    end else if (bus.start) begin
                        state_reg       <= CLEAR;
                        clr_cnt_reg     <= '0;
                        cycle_count_reg <= '0;
                        core_rst_reg    <= 1'b1;
                        busy_reg        <= 1'b1;
                        done_reg        <= 1'b0;
                        timeout_reg     <= 1'b0;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    core_rst_reg <= 1'b1;
                    core_en_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    timeout_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_rst    = core_rst_reg;
    assign bus.core_en     = core_en_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_core_run_controller.sv
// -----------------------------------------------------------------------------
// tb_core_run_controller
// Drives start/abort and per-cycle pc/mach_code vectors into the controller.
// The driver pushes the expected end-of-run result into a queue; an
// independent monitor pops it when done rises or busy drops without done.
// -----------------------------------------------------------------------------
module tb_core_run_controller;

    localparam int         CLEAR_CYCLES = 2;
    localparam int         HALT_ZEROS   = 2;
    localparam logic [7:0] HALT_PC      = 8'hFF;
    localparam int         MAX_CYCLES   = 10;
    localparam int         LMAX         = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    core_run_controller_if #(.PC_W(8), .INSTR_W(9), .CNT_W(16)) bus ();

    core_run_controller #(
        .PC_W         (8),
        .INSTR_W      (9),
        .CNT_W        (16),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .HALT_ZEROS   (HALT_ZEROS),
        .HALT_PC      (HALT_PC),
        .MAX_CYCLES   (16'd10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit is_abort;
        int count;
        bit to;
        int en;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [8:0] mach_v[LMAX];
    logic [7:0] pc_v[LMAX];

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: walk the vector stream applying the end-of-program rules.
    // Halt is tested before the budget so a coincident halt wins.
    function automatic void model(output int n, output bit to);
        int zrun = 0;
        n  = -1;
        to = 1'b0;
        for (int i = 0; i < LMAX; i++) begin
            zrun = (mach_v[i] == 9'h000) ? zrun + 1 : 0;
            if (pc_v[i] == HALT_PC || zrun >= HALT_ZEROS) begin
                n = i + 1;
                return;
            end
            if (i + 1 == MAX_CYCLES) begin
                n  = MAX_CYCLES;
                to = 1'b1;
                return;
            end
        end
    endfunction

    // abort_at: -2 none, -1 during CLEAR, k>=0 with RUN vector k
    task automatic do_run(input int abort_at, input bit hold);
        bit   finished = 1'b0;
        int   n;
        bit   to;
        exp_t e;
        model(n, to);
        if (abort_at == -1)     e = '{1'b1, 0, 1'b0, 0};
        else if (abort_at >= 0) e = '{1'b1, abort_at, 1'b0, abort_at + 1};
        else                    e = '{1'b0, n, to, n};
        exp_q.push_back(e);

        if (!bus.start) begin
            @(negedge clk);
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = hold;
        @(negedge clk);
        if (abort_at == -1) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            return;
        end
        for (int k = 0; k < LMAX; k++) begin
            @(negedge clk);
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            bus.mach_code = mach_v[k];
            bus.pc        = pc_v[k];
            if (k == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                finished  = 1'b1;
                break;
            end
        end
        if (!finished) begin
            @(negedge clk);
            finished = bus.done;
        end
        check("run_completes", finished, 1);
        bus.mach_code = 9'h1AB;
        bus.pc        = 8'h00;
    endtask

    task automatic gen_random();
        for (int i = 0; i < LMAX; i++) begin
            mach_v[i] = ($urandom_range(0, 4) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
            pc_v[i]   = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        end
    endtask

    task automatic gen_basic();
        for (int i = 0; i < LMAX; i++) begin
            mach_v[i] = (i < 5) ? 9'(9'h0C3 + i) : 9'h000;
            pc_v[i]   = 8'(i);
        end
    endtask

    // Monitor
    initial begin
        int   en_cnt = 0, rst_cnt = 0, held_count = 0, runs = 0;
        bit   prev_busy = 1'b0, prev_done = 1'b0, held_to = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.busy && !prev_busy) begin
                    en_cnt  = 0;
                    rst_cnt = 0;
                    check("start_clears_count", bus.cycle_count, 0);
                    check("start_clears_done", bus.done, 0);
                end
                if (bus.busy && bus.core_rst) rst_cnt++;
                if (bus.core_en) en_cnt++;
                if ((bus.done && !prev_done) || (prev_busy && !bus.busy && !bus.done)) begin
                    runs++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_end: got run end, required none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("end_kind_abort", !bus.done, e.is_abort);
                        check("cycle_count", bus.cycle_count, e.count);
                        check("timeout", bus.timeout, e.to);
                        check("core_en_cycles", en_cnt, e.en);
                        check("core_rst_cycles", rst_cnt, CLEAR_CYCLES);
                        check("core_en_off", bus.core_en, 0);
                        check("core_rst_end", bus.core_rst, e.is_abort);
                        $display("[TB] run %0d: %s count=%0d timeout=%0d en=%0d",
                                 runs, e.is_abort ? "abort" : "done",
                                 bus.cycle_count, bus.timeout, en_cnt);
                    end
                    held_count = int'(bus.cycle_count);
                    held_to    = bus.timeout;
                end else if (bus.done && prev_done) begin
                    check("done_hold_count", bus.cycle_count, held_count);
                    check("done_hold_timeout", bus.timeout, held_to);
                end
                prev_busy = bus.busy;
                prev_done = bus.done;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish by 1000000");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        int n;
        bit to;
        int ab;
        bit hold;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.pc        = 8'h00;
        bus.mach_code = 9'h1AB;

        // Reset held with start high: nothing may move.
        repeat (3) begin
            @(negedge clk);
            check("rst_core_rst", bus.core_rst, 1);
            check("rst_core_en", bus.core_en, 0);
            check("rst_done", bus.done, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_timeout", bus.timeout, 0);
            check("rst_count", bus.cycle_count, 0);
        end
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_core_rst", bus.core_rst, 1);
        end

        // 5 nonzero words then two zeros: 7 RUN cycles.
        gen_basic();
        do_run(-2, 1'b0);
        repeat (3) @(negedge clk);

        // Isolated zeros never halt; the budget ends the run.
        for (int i = 0; i < LMAX; i++) begin
            mach_v[i] = (i % 2 == 1) ? 9'h000 : 9'h055;
            pc_v[i]   = 8'(i + 1);
        end
        do_run(-2, 1'b0);

        // Terminal PC on the budget's last cycle: halt wins.
        for (int i = 0; i < LMAX; i++) begin
            mach_v[i] = 9'h111;
            pc_v[i]   = (i == MAX_CYCLES - 1) ? 8'hFF : 8'(i);
        end
        do_run(-2, 1'b0);

        // Abort mid-RUN, then a clean restart.
        gen_basic();
        do_run(3, 1'b0);
        repeat (2) @(negedge clk);
        do_run(-2, 1'b0);

        // Abort during CLEAR.
        do_run(-1, 1'b0);

        // Back-to-back: start held through DONE.
        gen_basic();
        do_run(-2, 1'b1);
        gen_random();
        do_run(-2, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 40; r++) begin
            gen_random();
            model(n, to);
            ab   = -2;
            hold = 1'b0;
            case ($urandom_range(0, 7))
                0: ab = $urandom_range(0, n - 1);
                1: ab = -1;
                2, 3: hold = (r < 39);
                default: ;
            endcase
            do_run(ab, hold);
            if (!bus.start) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
